handshake_constant_arbiter: RTL and testbench
=============================================

// Module: handshake_constant_arbiter
// PURPOSE
//  Shares one constant-source channel among N_REQ control requesters in the elastic dataflow netlist.
//  Arbitrates round-robin among valid ctrl tokens and consumes one token per cycle.
//  Emits CONST_VALUE plus the winner index through a one-slot registered output buffer.
//  Downstream logic uses outs_idx to steer the result back to the originating basic block.
// PARAMETERS
//  DATA_WIDTH   32            width of outs
//  N_REQ        4             number of ctrl requester channels (>=1)
//  IDX_WIDTH    2             width of outs_idx; 2**IDX_WIDTH >= N_REQ
//  CONST_VALUE  32'h0000_0000 constant emitted on outs (truncated/zero-extended to DATA_WIDTH)
//  CNT_WIDTH    16            width of issue_count (optional feature only)
// PORTS
//  clk          in   1           clock, all state on rising edge
//  rst          in   1           asynchronous, active-high reset
//  ctrl_valid   in   N_REQ       per-requester token valid
//  ctrl_ready   out  N_REQ       per-requester token accept (at most one bit high)
//  outs         out  DATA_WIDTH  constant data, always CONST_VALUE
//  outs_idx     out  IDX_WIDTH   index of requester whose token is held in the buffer
//  outs_valid   out  1           output buffer full
//  outs_ready   in   1           downstream accept
//  issue_count  out  CNT_WIDTH   only with HANDSHAKE_CONST_ARB_CNT_EN
// BEHAVIOUR
//  - Reset (async assert, sync release): full=0, outs_valid=0, outs_idx=0, ptr=0, issue_count=0.
//    outs=CONST_VALUE at all times, including during reset.
//  - Buffer states: EMPTY (full=0) and FULL (full=1). outs_valid=full.
//  - can_accept = !full | outs_ready. This is a pipeline-ready buffer: drain and fill happen in the same cycle.
//  - Grant: one-hot. Search ctrl_valid starting at index ptr, upward, wrapping mod N_REQ.
//    The first valid bit wins. grant=0 when no ctrl_valid bit is set.
//  - ctrl_ready[i] = can_accept & grant[i]. ctrl_ready may depend on ctrl_valid.
//    It never depends on any other requester's ready.
//  - Fire: fire = |(ctrl_valid & ctrl_ready). On fire, next cycle full=1, outs_idx=winner,
//    and ptr=(winner+1) mod N_REQ.
//  - Latency 1 cycle from token accept to outs_valid. Throughput 1 token/cycle when outs_ready=1.
//  - Transitions:
//    EMPTY -> FULL   on fire.
//    FULL  -> EMPTY  on outs_ready & !fire.
//    FULL  -> FULL   on outs_ready & fire; outs_idx reloads.
//    FULL  -> FULL   on !outs_ready; nothing changes.
//  - Stall: while outs_valid=1 & outs_ready=0, outs/outs_idx/outs_valid hold stable.
//    All ctrl_ready=0 and ptr is frozen.
//  - No valid requester: no fire, ptr unchanged.
//  - Fairness: a continuously-valid requester is granted within N_REQ fires.
//  - N_REQ=1: degenerates to a registered constant. ptr stays 0; outs_idx=0.
//  - Reset mid-operation: any buffered token is dropped (outs_valid=0 at once); ptr returns to 0.
//  - No combinational path from outs_ready to outs_valid. outs_ready->ctrl_ready is combinational.
// CONFIGURATION
//  - HANDSHAKE_CONST_ARB_CNT_EN defined:
//    issue_count port exists; +1 on every outs handshake (outs_valid & outs_ready).
//    Wraps 2**CNT_WIDTH-1 -> 0. Reset to 0.
//  - HANDSHAKE_CONST_ARB_CNT_EN undefined:
//    issue_count port and counter are absent. All other behaviour is identical.
// TESTING
//  1. Reset: assert rst mid-FULL (outs_idx=2) -> outs_valid=0, outs_idx=0 immediately.
//     First grant after release goes to lowest valid index.
//  2. Round-robin: N_REQ=4, ctrl_valid=4'b1111, outs_ready=1 -> outs_idx 0,1,2,3,0,... one per cycle.
//     ctrl_ready one-hot each cycle.
//  3. Skip idle: ctrl_valid=4'b1010 continuously -> outs_idx alternates 1,3,1,3. Requesters 0 and 2 never readied.
//  4. Backpressure: fill with idx 1, hold outs_ready=0 for 5 cycles -> outs_idx=1, outs_valid=1 stable,
//     ctrl_ready=0. Release -> next grant is idx 2 in the same cycle.
//  5. Drain+fill: FULL, outs_ready=1, ctrl_valid=4'b0001 -> no empty bubble; outs_valid stays 1.
//     outs_idx becomes 0. outs=CONST_VALUE throughout.
//  6. With HANDSHAKE_CONST_ARB_CNT_EN, CNT_WIDTH=4: 17 handshakes -> issue_count=1 (wrap).
//     Stalled cycles do not count.

Source files
------------

// File: rtl/handshake_constant_arbiter.sv
// Round-robin share of one constant source among N_REQ ctrl requesters; optional issue counter under HANDSHAKE_CONST_ARB_CNT_EN.
// Latency: 1 cycle from ctrl token accept to outs_valid; 1 token/cycle when outs_ready=1.
// Backpressure: pipeline-ready one-slot buffer; ctrl_ready drops to 0 only while full and outs_ready=0.
module handshake_constant_arbiter #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    N_REQ       = 4,
    parameter int                    IDX_WIDTH   = 2,
    parameter logic [DATA_WIDTH-1:0] CONST_VALUE = '0
`ifdef HANDSHAKE_CONST_ARB_CNT_EN
    ,
    parameter int                    CNT_WIDTH   = 16
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      ctrl_valid,
    output logic [N_REQ-1:0]      ctrl_ready,
    output logic [DATA_WIDTH-1:0] outs,
    output logic [IDX_WIDTH-1:0]  outs_idx,
    output logic                  outs_valid,
    input  logic                  outs_ready
`ifdef HANDSHAKE_CONST_ARB_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]  issue_count
`endif
);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t               state, state_nxt;
    logic [IDX_WIDTH-1:0] ptr, ptr_nxt;
    logic [IDX_WIDTH-1:0] idx_nxt;
    logic [IDX_WIDTH-1:0] win_idx;
    logic [N_REQ-1:0]     grant;
    logic                 can_accept;
    logic                 fire;
    int                   best;
    int                   off;

    assign outs       = CONST_VALUE;
    assign outs_valid = (state == FULL);
    assign can_accept = (state == EMPTY) | outs_ready;
    assign ctrl_ready = grant & {N_REQ{can_accept}};
    assign fire       = |(ctrl_valid & ctrl_ready);

    // Winner is the valid requester with the smallest circular distance from ptr.
    always_comb begin
        grant   = '0;
        win_idx = '0;
        best    = N_REQ;
        off     = 0;
        for (int i = 0; i < N_REQ; i++) begin
            if (ctrl_valid[i]) begin
                off = (i >= int'(ptr)) ? (i - int'(ptr)) : (i + N_REQ - int'(ptr));
                if (off < best) begin
                    best     = off;
                    grant    = '0;
                    grant[i] = 1'b1;
                    win_idx  = IDX_WIDTH'(i);
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = outs_idx;
        ptr_nxt   = ptr;
        case (state)
            EMPTY: begin
                if (fire) begin
                    state_nxt = FULL;
                end
            end
            FULL: begin
                if (outs_ready && !fire) begin
                    state_nxt = EMPTY;
                end
            end
            default: state_nxt = EMPTY;
        endcase
        if (fire) begin
            idx_nxt = win_idx;
            ptr_nxt = (int'(win_idx) == N_REQ - 1) ? '0 : win_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= EMPTY;
            outs_idx <= '0;
            ptr      <= '0;
        end else begin
            state    <= state_nxt;
            outs_idx <= idx_nxt;
            ptr      <= ptr_nxt;
        end
    end

`ifdef HANDSHAKE_CONST_ARB_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_count <= '0;
        end else if (outs_valid && outs_ready) begin
            issue_count <= issue_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_handshake_constant_arbiter.sv
// Directed bench for handshake_constant_arbiter (N_REQ=4); counter scenario built with HANDSHAKE_CONST_ARB_CNT_EN.
module tb_handshake_constant_arbiter;

    localparam logic [31:0] CV = 32'hC0DE_1234;

    logic        clk;
    logic        rst;
    logic [3:0]  ctrl_valid;
    logic [3:0]  ctrl_ready;
    logic [31:0] outs;
    logic [1:0]  outs_idx;
    logic        outs_valid;
    logic        outs_ready;
`ifdef HANDSHAKE_CONST_ARB_CNT_EN
    logic [3:0]  issue_count;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    handshake_constant_arbiter #(
        .DATA_WIDTH (32),
        .N_REQ      (4),
        .IDX_WIDTH  (2),
        .CONST_VALUE(CV)
`ifdef HANDSHAKE_CONST_ARB_CNT_EN
        ,
        .CNT_WIDTH  (4)
`endif
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ctrl_valid (ctrl_valid),
        .ctrl_ready (ctrl_ready),
        .outs       (outs),
        .outs_idx   (outs_idx),
        .outs_valid (outs_valid),
        .outs_ready (outs_ready)
`ifdef HANDSHAKE_CONST_ARB_CNT_EN
        ,
        .issue_count(issue_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    // Entered and left at posedge+1.
    task automatic do_reset();
        rst        = 1'b1;
        ctrl_valid = 4'b0000;
        outs_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        ctrl_valid = 4'b0000;
        outs_ready = 1'b0;
        #1;
        total_cnt++;
        if (outs_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", outs_valid); else pass_cnt++;
        total_cnt++;
        if (outs_idx !== 2'd0) $display("FAIL reset_idx: got %0d want 0", outs_idx); else pass_cnt++;
        total_cnt++;
        if (outs !== CV) $display("FAIL reset_outs: got %h want %h", outs, CV); else pass_cnt++;
`ifdef HANDSHAKE_CONST_ARB_CNT_EN
        total_cnt++;
        if (issue_count !== 4'd0) $display("FAIL reset_count: got %0d want 0", issue_count); else pass_cnt++;
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        // Fill with idx 2 and hold it, then reset mid-FULL.
        ctrl_valid = 4'b0100;
        #1;
        total_cnt++;
        if (ctrl_ready !== 4'b0100) $display("FAIL reset_fill_ready: got %b want 0100", ctrl_ready); else pass_cnt++;
        @(posedge clk); #1;
        ctrl_valid = 4'b0000;
        total_cnt++;
        if (outs_valid !== 1'b1 || outs_idx !== 2'd2)
            $display("FAIL reset_full_idx2: got valid=%b idx=%0d want valid=1 idx=2", outs_valid, outs_idx);
        else pass_cnt++;
        #2;
        rst = 1'b1;
        #1;
        total_cnt++;
        if (outs_valid !== 1'b0 || outs_idx !== 2'd0)
            $display("FAIL reset_async: got valid=%b idx=%0d want valid=0 idx=0", outs_valid, outs_idx);
        else pass_cnt++;
        total_cnt++;
        if (outs !== CV) $display("FAIL reset_async_outs: got %h want %h", outs, CV); else pass_cnt++;
        #1;
        rst = 1'b0;
        // ptr was 3 before reset; 1100 would pick 3 without ptr clearing.
        ctrl_valid = 4'b1100;
        outs_ready = 1'b1;
        #1;
        total_cnt++;
        if (ctrl_ready !== 4'b0100) $display("FAIL reset_first_grant: got %b want 0100", ctrl_ready); else pass_cnt++;
        @(posedge clk); #1;
        ctrl_valid = 4'b0000;
        total_cnt++;
        if (outs_valid !== 1'b1 || outs_idx !== 2'd2)
            $display("FAIL reset_first_out: got valid=%b idx=%0d want valid=1 idx=2", outs_valid, outs_idx);
        else pass_cnt++;
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_r;
        do_reset();
        ctrl_valid = 4'b1111;
        outs_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            exp_r = 4'b0001 << (k % 4);
            #1;
            total_cnt++;
            if (ctrl_ready !== exp_r) $display("FAIL rr_ready[%0d]: got %b want %b", k, ctrl_ready, exp_r); else pass_cnt++;
            @(posedge clk); #1;
            total_cnt++;
            if (outs_valid !== 1'b1 || outs_idx !== 2'(k % 4) || outs !== CV)
                $display("FAIL rr_out[%0d]: got valid=%b idx=%0d outs=%h want valid=1 idx=%0d outs=%h",
                         k, outs_valid, outs_idx, outs, k % 4, CV);
            else pass_cnt++;
        end
    endtask

    task automatic test_skip_idle();
        logic [1:0] exp_i;
        logic [3:0] exp_r;
        do_reset();
        ctrl_valid = 4'b1010;
        outs_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            exp_i = (k % 2 == 0) ? 2'd1 : 2'd3;
            exp_r = 4'b0001 << exp_i;
            #1;
            total_cnt++;
            if (ctrl_ready !== exp_r) $display("FAIL skip_ready[%0d]: got %b want %b", k, ctrl_ready, exp_r); else pass_cnt++;
            @(posedge clk); #1;
            total_cnt++;
            if (outs_valid !== 1'b1 || outs_idx !== exp_i)
                $display("FAIL skip_out[%0d]: got valid=%b idx=%0d want valid=1 idx=%0d", k, outs_valid, outs_idx, exp_i);
            else pass_cnt++;
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        ctrl_valid = 4'b0010;
        outs_ready = 1'b0;
        @(posedge clk); #1;
        ctrl_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1;
            total_cnt++;
            if (outs_valid !== 1'b1 || outs_idx !== 2'd1 || ctrl_ready !== 4'b0000 || outs !== CV)
                $display("FAIL stall[%0d]: got valid=%b idx=%0d ready=%b outs=%h want valid=1 idx=1 ready=0000 outs=%h",
                         k, outs_valid, outs_idx, ctrl_ready, outs, CV);
            else pass_cnt++;
            @(posedge clk); #1;
        end
        outs_ready = 1'b1;
        #1;
        total_cnt++;
        if (ctrl_ready !== 4'b0100) $display("FAIL stall_release_ready: got %b want 0100", ctrl_ready); else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (outs_valid !== 1'b1 || outs_idx !== 2'd2)
            $display("FAIL stall_release_out: got valid=%b idx=%0d want valid=1 idx=2", outs_valid, outs_idx);
        else pass_cnt++;
    endtask

    task automatic test_drain_fill();
        do_reset();
        ctrl_valid = 4'b0100;
        outs_ready = 1'b0;
        @(posedge clk); #1;
        ctrl_valid = 4'b0001;
        outs_ready = 1'b1;
        #1;
        total_cnt++;
        if (ctrl_ready !== 4'b0001 || outs_valid !== 1'b1)
            $display("FAIL drain_fill_ready: got ready=%b valid=%b want ready=0001 valid=1", ctrl_ready, outs_valid);
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (outs_valid !== 1'b1 || outs_idx !== 2'd0 || outs !== CV)
            $display("FAIL drain_fill_out: got valid=%b idx=%0d outs=%h want valid=1 idx=0 outs=%h",
                     outs_valid, outs_idx, outs, CV);
        else pass_cnt++;
        ctrl_valid = 4'b0000;
        @(posedge clk); #1;
        total_cnt++;
        if (outs_valid !== 1'b0) $display("FAIL drain_empty: got valid=%b want 0", outs_valid); else pass_cnt++;
    endtask

    task automatic test_no_valid();
        do_reset();
        ctrl_valid = 4'b1000;
        outs_ready = 1'b1;
        @(posedge clk); #1;
        ctrl_valid = 4'b0000;
        repeat (3) begin
            @(posedge clk); #1;
        end
        total_cnt++;
        if (outs_valid !== 1'b0 || ctrl_ready !== 4'b0000)
            $display("FAIL idle: got valid=%b ready=%b want valid=0 ready=0000", outs_valid, ctrl_ready);
        else pass_cnt++;
        // ptr left at 0 after the idx-3 grant; idle cycles must not move it.
        ctrl_valid = 4'b1111;
        #1;
        total_cnt++;
        if (ctrl_ready !== 4'b0001) $display("FAIL idle_ptr: got ready=%b want 0001", ctrl_ready); else pass_cnt++;
        ctrl_valid = 4'b0000;
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

`ifdef HANDSHAKE_CONST_ARB_CNT_EN
    task automatic test_count();
        do_reset();
        ctrl_valid = 4'b1111;
        outs_ready = 1'b0;
        @(posedge clk); #1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        total_cnt++;
        if (issue_count !== 4'd0) $display("FAIL cnt_stall: got %0d want 0", issue_count); else pass_cnt++;
        outs_ready = 1'b1;
        repeat (15) begin
            @(posedge clk); #1;
        end
        total_cnt++;
        if (issue_count !== 4'd15) $display("FAIL cnt_15: got %0d want 15", issue_count); else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (issue_count !== 4'd0) $display("FAIL cnt_wrap16: got %0d want 0", issue_count); else pass_cnt++;
        ctrl_valid = 4'b0000;
        @(posedge clk); #1;
        total_cnt++;
        if (issue_count !== 4'd1 || outs_valid !== 1'b0)
            $display("FAIL cnt_17: got count=%0d valid=%b want count=1 valid=0", issue_count, outs_valid);
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (issue_count !== 4'd1) $display("FAIL cnt_hold: got %0d want 1", issue_count); else pass_cnt++;
    endtask
`endif

    initial begin
        test_reset();
        test_round_robin();
        test_skip_idle();
        test_backpressure();
        test_drain_fill();
        test_no_valid();
`ifdef HANDSHAKE_CONST_ARB_CNT_EN
        test_count();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
